// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NREQ valid/ready requesters.
// Define FIFO_ARB_STATS_EN to build saturating per-requester transfer counters on stat_cnt.
module fifo_wr_arbiter #(
    parameter  int NREQ     = 4,
    parameter  int DSIZE    = 6,
    parameter  int MAXBURST = 4,
    localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW       = $clog2(MAXBURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic [DSIZE-1:0]      wdata,
    output logic                  winc,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [NREQ*16-1:0]    stat_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;

    logic            any_valid;
    logic [GW-1:0]   pick;
    logic [GW:0]     idx;
    logic            g_valid;
    logic [DSIZE-1:0] g_data;
    logic            xfer;

    // First valid requester at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        any_valid = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
            if (!any_valid && req_valid[idx[GW-1:0]]) begin
                any_valid = 1'b1;
                pick      = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid = req_valid[i];
                g_data  = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign xfer = (state_q == GRANT) && g_valid && !wfull;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        burst_d   = burst_q;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = pick;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NREQ; i++)
                    req_ready[i] = (grant_q == GW'(i)) && !wfull;
                winc = xfer;
                if (xfer) begin
                    wdata   = g_data;
                    burst_d = burst_q + BW'(1);
                end
                // A full FIFO only stalls; release comes from burst end or a dropped valid.
                if (!g_valid || (xfer && burst_q == BW'(MAXBURST - 1))) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            burst_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            // NOTE: the counter array is reset explicitly because reset is the only way to clear it.
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NREQ; i++)
                if (grant_q == GW'(i) && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester word queues as scoreboard,
// plus a round-robin grant model checked by a negedge monitor.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 6;
    localparam int MAXBURST = 4;
    localparam int GW       = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic [DSIZE-1:0]      wdata;
    logic                  winc;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic [NREQ*16-1:0]    stat_cnt;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .wdata(wdata), .winc(winc),
        .grant_id(grant_id), .busy(busy), .stat_cnt(stat_cnt)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DSIZE-1:0] src_q [NREQ][$];
    logic [DSIZE-1:0] exp_q [NREQ][$];

    int m_ptr, m_g, exp_g, n_in_grant, m_idx;
    bit prev_busy, prev_vg, pend, found;
    int m_stat [NREQ];
    int grant_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: grant model and data scoreboard, evaluated mid-cycle.
    always @(negedge wclk) begin
        if (!wrst_n) begin
            m_ptr = 0; m_g = 0; prev_busy = 0; prev_vg = 0; n_in_grant = 0; pend = 0;
            for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
        end else begin
            if (prev_busy) begin
                check("release", {31'd0, busy}, {31'd0, !(n_in_grant == MAXBURST || !prev_vg)});
                if (!busy) m_ptr = (m_g + 1) % NREQ;
            end else if (pend) begin
                check("arb_latency", {31'd0, busy}, 32'd1);
                check("grant_id", {30'd0, grant_id}, exp_g);
                m_g = exp_g; n_in_grant = 0; pend = 0;
                grant_log.push_back(exp_g);
            end else begin
                check("stay_idle", {31'd0, busy}, 32'd0);
            end

            if (busy) begin
                check("grant_hold", {30'd0, grant_id}, m_g);
                check("req_ready", {28'd0, req_ready}, wfull ? 32'd0 : (32'd1 << m_g));
                check("winc", {31'd0, winc}, {31'd0, req_valid[m_g] && !wfull});
                if (winc) begin
                    check("word_available", {31'd0, exp_q[m_g].size() > 0}, 32'd1);
                    if (exp_q[m_g].size() > 0) check("wdata", {26'd0, wdata}, {26'd0, exp_q[m_g].pop_front()});
                    n_in_grant++;
                    if (m_stat[m_g] < 16'hFFFF) m_stat[m_g]++;
                end else begin
                    check("wdata_zero", {26'd0, wdata}, 32'd0);
                end
            end else begin
                check("idle_outputs", {21'd0, winc, req_ready, wdata}, 32'd0);
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (!found && req_valid[m_idx]) begin
                        found = 1;
                        exp_g = m_idx;
                    end
                end
                pend = found;
            end
            prev_vg   = req_valid[m_g];
            prev_busy = busy;
        end
    end

    task automatic push(input int i, input logic [DSIZE-1:0] w);
        src_q[i].push_back(w);
        exp_q[i].push_back(w);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DSIZE +: DSIZE] = src_q[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
            end
        end
    endtask

    // One clock: sample the handshake mid-cycle, retire accepted words after the edge.
    task automatic cycle();
        logic [NREQ-1:0] fire;
        @(negedge wclk);
        fire = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) if (fire[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            done = (busy == 1'b0);
            for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) done = 0;
            if (!done) cycle();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_stats(input string name);
        for (int i = 0; i < NREQ; i++) begin
`ifdef FIFO_ARB_STATS_EN
            check(name, {16'd0, stat_cnt[i*16 +: 16]}, m_stat[i]);
`else
            check(name, {16'd0, stat_cnt[i*16 +: 16]}, 32'd0);
`endif
        end
    endtask

    int s0;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        wrst_n = 1'b0; wfull = 1'b0; req_valid = '0; req_data = '0;
        #1;
        check("rst_winc", {31'd0, winc}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_wdata", {26'd0, wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_stat", {31'd0, stat_cnt != '0}, 32'd0);
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;

        // All requesters continuously valid for two full rounds.
        grant_log.delete();
        for (int w = 0; w < 8; w++) for (int i = 0; i < NREQ; i++) push(i, DSIZE'($urandom));
        drive();
        wait_idle("rr_rounds_done", 200);
        check("rr_log_len", grant_log.size(), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) check("rr_order", grant_log[k], exp_order[k]);
        for (int i = 0; i < NREQ; i++) begin
`ifdef FIFO_ARB_STATS_EN
            check("stat_two_rounds", {16'd0, stat_cnt[i*16 +: 16]}, 32'd8);
`else
            check("stat_tied_zero", {16'd0, stat_cnt[i*16 +: 16]}, 32'd0);
`endif
        end

        // Single requester, three words, then valid drops.
        s0 = m_stat[0];
        push(0, 6'h11); push(0, 6'h12); push(0, 6'h13);
        drive();
        cycle();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_grant", {30'd0, grant_id}, 32'd0);
        wait_idle("t1_done", 50);
        check("t1_words", m_stat[0] - s0, 32'd3);
        for (int i = 0; i < NREQ; i++) push(i, DSIZE'($urandom));
        drive();
        cycle();
        check("t1_rr_ptr_next", {30'd0, grant_id}, 32'd1);
        wait_idle("t1_all_done", 100);

        // Wrap-around: last grant 3, then requesters 0 and 2.
        push(3, DSIZE'($urandom));
        drive();
        wait_idle("t5_r3_done", 50);
        push(0, DSIZE'($urandom)); push(2, DSIZE'($urandom));
        drive();
        cycle();
        check("t5_wrap_grant", {30'd0, grant_id}, 32'd0);
        wait_idle("t5_done", 50);

        // FIFO full for five cycles after the second word of a burst.
        s0 = m_stat[0];
        for (int w = 0; w < 4; w++) push(0, DSIZE'($urandom));
        drive();
        begin
            bit hit = 0;
            for (int c = 0; c < 20 && !hit; c++) begin
                cycle();
                hit = busy && (m_g == 0) && (n_in_grant == 2);
            end
            check("t3_two_words", {31'd0, hit}, 32'd1);
        end
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_stall_busy", {31'd0, busy}, 32'd1);
            check("t3_stall_winc", {31'd0, winc}, 32'd0);
            check("t3_stall_ready", {28'd0, req_ready}, 32'd0);
            check("t3_stall_grant", {30'd0, grant_id}, 32'd0);
            cycle();
        end
        wfull = 1'b0;
        wait_idle("t3_done", 50);
        check("t3_words", m_stat[0] - s0, 32'd4);

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (src_q[i].size() < 3 && $urandom_range(0, 2) == 0) push(i, DSIZE'($urandom));
            wfull = ($urandom_range(0, 3) == 0);
            drive();
            cycle();
        end
        wfull = 1'b0;
        wait_idle("rand_drain", 400);
        check_stats("stat_after_random");

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < NREQ; i++) for (int w = 0; w < 4; w++) push(i, DSIZE'($urandom));
        drive();
        repeat (3) cycle();
        #3 wrst_n = 1'b0;
        #1;
        check("t4_winc_async", {31'd0, winc}, 32'd0);
        check("t4_ready_async", {28'd0, req_ready}, 32'd0);
        check("t4_busy_async", {31'd0, busy}, 32'd0);
        check("t4_stat_async", {31'd0, stat_cnt != '0}, 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        repeat (2) cycle();
        push(1, DSIZE'($urandom)); push(1, DSIZE'($urandom));
        push(3, DSIZE'($urandom)); push(3, DSIZE'($urandom));
        drive();
        wrst_n = 1'b1;
        cycle();
        cycle();
        check("t4_restart_grant", {30'd0, grant_id}, 32'd1);
        check("t4_restart_busy", {31'd0, busy}, 32'd1);
        wait_idle("t4_done", 50);
        check_stats("stat_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
